// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/busy/done handshake and registered Z/C/N/V flags.
// Build option: define ALU_SEQ_MUL_EN to include the shift-add multiplier (opcode 8).

module alu_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OP_BITS-1:0]    alu_op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  Z,
    output logic                  C,
    output logic                  N,
    output logic                  V
);

    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [OP_BITS-1:0] OP_ADD   = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_SUB   = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_AND   = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_OR    = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_XOR   = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] OP_SHL   = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] OP_SHR   = OP_BITS'(6);
    localparam logic [OP_BITS-1:0] OP_PASSB = OP_BITS'(7);

`ifdef ALU_SEQ_MUL_EN
    localparam logic [OP_BITS-1:0] OP_MUL = OP_BITS'(8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [5:0]              r_cnt;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [OP_BITS-1:0]    r_op;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_z;
    logic                  r_c;
    logic                  r_n;
    logic                  r_v;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]   w_shl;
    logic [DATA_WIDTH:0]   w_shr;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_c;
    logic                  w_v;

    generate
        if (DATA_WIDTH >= 5) begin : g_shamtDirect
            assign w_shamt = r_b[4:0];
        end else begin : g_shamtExtend
            assign w_shamt = 5'(r_b);
        end
    endgenerate

    // Shifts run one bit wider so the last bit shifted out lands in a known position.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} + {1'b0, ~r_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign w_shl  = {1'b0, r_a} << w_shamt;
    assign w_shr  = {r_a, 1'b0} >> w_shamt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[DATA_WIDTH];
                w_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[DATA_WIDTH];
                w_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            OP_AND:   w_res = r_a & r_b;
            OP_OR:    w_res = r_a | r_b;
            OP_XOR:   w_res = r_a ^ r_b;
            OP_SHL: begin
                w_res = w_shl[MSB:0];
                w_c   = w_shl[DATA_WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[DATA_WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_PASSB: w_res = r_b;
            default: begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    // Operands are captured on acceptance so later input changes cannot disturb the operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b1;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= A;
                        r_b    <= B;
                        r_op   <= alu_op;
                        r_busy <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                        if (alu_op == OP_MUL) begin
                            r_state  <= S_MUL;
                            r_acc    <= '0;
                            r_mcand  <= {{DATA_WIDTH{1'b0}}, A};
                            r_mplier <= B;
                            r_cnt    <= '0;
                        end else begin
                            r_state <= S_EXEC;
                        end
`else
                        r_state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    r_result <= w_res;
                    r_z      <= (w_res == '0);
                    r_c      <= w_c;
                    r_n      <= w_res[MSB];
                    r_v      <= w_v;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
`ifdef ALU_SEQ_MUL_EN
                // One partial product per cycle; the extra cycle after the last step publishes the product.
                S_MUL: begin
                    if (r_cnt == 6'(DATA_WIDTH)) begin
                        r_result <= r_acc[MSB:0];
                        r_z      <= (r_acc[MSB:0] == '0);
                        r_c      <= |r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_n      <= r_acc[MSB];
                        r_v      <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 6'd1;
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign Z      = r_z;
    assign C      = r_c;
    assign N      = r_n;
    assign V      = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq; directed corner cases, handshake/reset scenarios,
// and randomized operations compared against an arithmetic reference model.

module tb_alu_seq;

    localparam int W   = 16;
    localparam int OPB = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [OPB-1:0] aluOp;
    logic [W-1:0]   opA;
    logic [W-1:0]   opB;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           zf;
    logic           cf;
    logic           nf;
    logic           vf;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.DATA_WIDTH(W), .OP_BITS(OPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .alu_op (aluOp),
        .A      (opA),
        .B      (opB),
        .busy   (busy),
        .done   (done),
        .result (result),
        .Z      (zf),
        .C      (cf),
        .N      (nf),
        .V      (vf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain integer arithmetic, result packed as {result, Z, C, N, V}.
    function automatic logic [W+3:0] refAlu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua;
        longint ub;
        longint modv;
        longint sa;
        longint sb;
        longint full;
        int s;
        logic [W-1:0] res;
        logic c;
        logic v;
        ua   = longint'(a);
        ub   = longint'(b);
        modv = longint'(1) << W;
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        s    = int'(ub & 31);
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            0: begin
                full = ua + ub;
                res  = W'(full);
                c    = (full >= modv);
                v    = ((sa + sb) > (modv / 2 - 1)) || ((sa + sb) < -(modv / 2));
            end
            1: begin
                full = ua - ub;
                res  = W'(full);
                c    = (ua >= ub);
                v    = ((sa - sb) > (modv / 2 - 1)) || ((sa - sb) < -(modv / 2));
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin
                full = ua << s;
                res  = W'(full);
                c    = (s != 0) && (((full >> W) & 1) != 0);
            end
            6: begin
                res = W'(ua >> s);
                c   = (s == 0) ? 1'b0 : (((ua >> (s - 1)) & 1) != 0);
            end
            7: res = b;
`ifdef ALU_SEQ_MUL_EN
            8: begin
                full = ua * ub;
                res  = W'(full);
                c    = (full >= modv);
            end
`endif
            default: res = '0;
        endcase
        return {res, (res == '0), c, res[W-1], v};
    endfunction

    function automatic int refLatency(input int op);
`ifdef ALU_SEQ_MUL_EN
        return (op == 8) ? W + 2 : 2;
`else
        return (op == 8) ? 2 : 2;
`endif
    endfunction

    // Runs one operation starting in an idle cycle; returns in the cycle after DONE.
    task automatic applyStimulus(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int lat, output logic [W+3:0] obs,
                                 output logic busyAcc, output logic idleAfter);
        start = 1'b1;
        aluOp = OPB'(op);
        opA   = a;
        opB   = b;
        @(posedge clk); #1;
        start   = 1'b0;
        aluOp   = OPB'($urandom);
        opA     = W'($urandom);
        opB     = W'($urandom);
        busyAcc = (busy === 1'b1) && (done === 1'b0);
        lat     = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        obs = {result, zf, cf, nf, vf};
        @(posedge clk); #1;
        idleAfter = (busy === 1'b0) && (done === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        aluOp = '0;
        opA   = '0;
        opB   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, zf, cf, nf, vf} !== {2'b00, {W{1'b0}}, 4'b1000}) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h required %h",
                     {busy, done, result, zf, cf, nf, vf}, {2'b00, {W{1'b0}}, 4'b1000});
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_no_start: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int           vOp[14];
        logic [W-1:0] vA[14];
        logic [W-1:0] vB[14];
        logic [W+3:0] vExp[14];
        int           vLat[14];
        int           lat;
        logic [W+3:0] obs;
        logic         busyAcc;
        logic         idleAfter;
        vOp[0]  = 0;  vA[0]  = 16'h7FFF; vB[0]  = 16'h0001; vExp[0]  = {16'h8000, 4'b0011}; vLat[0]  = 2;
        vOp[1]  = 1;  vA[1]  = 16'h1234; vB[1]  = 16'h1234; vExp[1]  = {16'h0000, 4'b1100}; vLat[1]  = 2;
        vOp[2]  = 1;  vA[2]  = 16'h0000; vB[2]  = 16'h0001; vExp[2]  = {16'hFFFF, 4'b0010}; vLat[2]  = 2;
        vOp[3]  = 5;  vA[3]  = 16'h8001; vB[3]  = 16'h0001; vExp[3]  = {16'h0002, 4'b0100}; vLat[3]  = 2;
        vOp[4]  = 6;  vA[4]  = 16'h0001; vB[4]  = 16'h0010; vExp[4]  = {16'h0000, 4'b1000}; vLat[4]  = 2;
        vOp[5]  = 15; vA[5]  = 16'h1234; vB[5]  = 16'h5678; vExp[5]  = {16'h0000, 4'b1000}; vLat[5]  = 2;
        vOp[6]  = 0;  vA[6]  = 16'hFFFF; vB[6]  = 16'h0001; vExp[6]  = {16'h0000, 4'b1100}; vLat[6]  = 2;
        vOp[7]  = 1;  vA[7]  = 16'h8000; vB[7]  = 16'h0001; vExp[7]  = {16'h7FFF, 4'b0101}; vLat[7]  = 2;
        vOp[8]  = 5;  vA[8]  = 16'h1234; vB[8]  = 16'h0000; vExp[8]  = {16'h1234, 4'b0000}; vLat[8]  = 2;
        vOp[9]  = 6;  vA[9]  = 16'hC000; vB[9]  = 16'h000F; vExp[9]  = {16'h0001, 4'b0100}; vLat[9]  = 2;
        vOp[10] = 7;  vA[10] = 16'h1111; vB[10] = 16'h8000; vExp[10] = {16'h8000, 4'b0010}; vLat[10] = 2;
        vOp[11] = 4;  vA[11] = 16'hAAAA; vB[11] = 16'hAAAA; vExp[11] = {16'h0000, 4'b1000}; vLat[11] = 2;
`ifdef ALU_SEQ_MUL_EN
        vOp[12] = 8;  vA[12] = 16'h0100; vB[12] = 16'h0100; vExp[12] = {16'h0000, 4'b1100}; vLat[12] = W + 2;
        vOp[13] = 8;  vA[13] = 16'h0007; vB[13] = 16'h0006; vExp[13] = {16'h002A, 4'b0000}; vLat[13] = W + 2;
`else
        vOp[12] = 8;  vA[12] = 16'h0100; vB[12] = 16'h0100; vExp[12] = {16'h0000, 4'b1000}; vLat[12] = 2;
        vOp[13] = 8;  vA[13] = 16'h0007; vB[13] = 16'h0006; vExp[13] = {16'h0000, 4'b1000}; vLat[13] = 2;
`endif
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vOp[i], vA[i], vB[i], lat, obs, busyAcc, idleAfter);
            checks++;
            if (obs !== vExp[i]) begin
                failures++;
                $display("[TB] FAIL directed[%0d] result_flags: got %h required %h", i, obs, vExp[i]);
            end
            checks++;
            if (lat !== vLat[i]) begin
                failures++;
                $display("[TB] FAIL directed[%0d] latency: got %0d required %0d", i, lat, vLat[i]);
            end
            checks++;
            if (busyAcc !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed[%0d] busy_after_accept: got %b required 1", i, busyAcc);
            end
            checks++;
            if (idleAfter !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed[%0d] idle_after_done: got %b required 1", i, idleAfter);
            end
        end
    endtask

    // A start during busy (and during DONE) must be dropped, leaving exactly one done pulse.
    task automatic test_start_while_busy();
        int           dones;
        logic [W+3:0] obs;
        logic [W+3:0] expd;
        obs = '0;
        start = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        aluOp = 4'd8; opA = 16'h0007; opB = 16'h0006;
        expd  = {16'h002A, 4'b0000};
`else
        aluOp = 4'd1; opA = 16'h0009; opB = 16'h0003;
        expd  = {16'h0006, 4'b0100};
`endif
        @(posedge clk); #1;
        aluOp = 4'd0;
        opA   = 16'h0001;
        opB   = 16'h0001;
        dones = 0;
        for (int k = 0; k < W + 10; k++) begin
            start = (k < 2);
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                obs = {result, zf, cf, nf, vf};
            end
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("[TB] FAIL busy_start_done_count: got %0d required 1", dones);
        end
        checks++;
        if (obs !== expd) begin
            failures++;
            $display("[TB] FAIL busy_start_result: got %h required %h", obs, expd);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_start_final_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_done_cycle_start();
        int n;
        start = 1'b1;
        aluOp = 4'd2;
        opA   = 16'hF0F0;
        opB   = 16'hFF00;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_cycle_wait: got done=%b required 1 within 50 cycles", done);
        end
        start = 1'b1;
        aluOp = 4'd0;
        opA   = 16'h0001;
        opB   = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_cycle_idle: got busy=%b done=%b required 0 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || result !== 16'hF000) begin
            failures++;
            $display("[TB] FAIL done_cycle_ignored: got busy=%b result=%h required 0 f000", busy, result);
        end
    endtask

    task automatic test_reset_mid_op();
        int           lat;
        logic [W+3:0] obs;
        logic         busyAcc;
        logic         idleAfter;
        int           sawDone;
        applyStimulus(0, 16'h0003, 16'h0004, lat, obs, busyAcc, idleAfter);
        checks++;
        if (obs !== {16'h0007, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL pre_reset_add: got %h required %h", obs, {16'h0007, 4'b0000});
        end
        start = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        aluOp = 4'd8; opA = 16'h00FF; opB = 16'h0101;
`else
        aluOp = 4'd0; opA = 16'h0100; opB = 16'h0023;
`endif
        @(posedge clk); #1;
        start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        repeat (4) @(posedge clk);
        #1;
`endif
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, zf, cf, nf, vf} !== {2'b00, {W{1'b0}}, 4'b1000}) begin
            failures++;
            $display("[TB] FAIL reset_mid_op_state: got %h required %h",
                     {busy, done, result, zf, cf, nf, vf}, {2'b00, {W{1'b0}}, 4'b1000});
        end
        @(posedge clk); #2;
        reset   = 1'b0;
        sawDone = 0;
        for (int k = 0; k < W + 6; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) sawDone++;
        end
        checks++;
        if (sawDone !== 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_op_quiet: got %0d active cycles required 0", sawDone);
        end
        applyStimulus(1, 16'h0000, 16'h0001, lat, obs, busyAcc, idleAfter);
        checks++;
        if (obs !== {16'hFFFF, 4'b0010} || lat !== 2) begin
            failures++;
            $display("[TB] FAIL post_reset_sub: got %h lat=%0d required %h lat=2",
                     obs, lat, {16'hFFFF, 4'b0010});
        end
    endtask

    task automatic test_random();
        int           op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] specials[4];
        int           lat;
        logic [W+3:0] obs;
        logic [W+3:0] expd;
        logic         busyAcc;
        logic         idleAfter;
        specials[0] = 16'h0000;
        specials[1] = 16'h7FFF;
        specials[2] = 16'h8000;
        specials[3] = 16'hFFFF;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            expd = refAlu(op, a, b);
            applyStimulus(op, a, b, lat, obs, busyAcc, idleAfter);
            checks++;
            if (obs !== expd || lat !== refLatency(op) || busyAcc !== 1'b1 || idleAfter !== 1'b1) begin
                failures++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d busy=%b idle=%b required %h lat=%0d 1 1",
                         i, op, a, b, obs, lat, busyAcc, idleAfter, expd, refLatency(op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_done_cycle_start();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
